chngy_writeback: RTL and testbench
==================================

// Module: chngy_writeback
// PURPOSE
// - Downstream of the change-in-Y update datapath: pairs each completed Y result
//   (result_in qualified by done_in) with the Y-matrix address issued upstream,
//   buffers (addr,data) pairs and writes them to Y memory via valid/ready.
// - Generates compute_en back-pressure to the upstream sequencer and a frame-complete pulse.
// PARAMETERS
// - DATA_W    48  complex Y word, {re[47:24], im[23:0]}; passed through unmodified
// - ADDR_W    10  Y-memory word address width
// - AQ_DEPTH  4   pending-address FIFO depth (power of 2, >=2)
// - WQ_DEPTH  4   write FIFO depth of {addr,data} pairs (power of 2, >=2)
// PORTS
// - clock       in   1       single clock, all logic on posedge
// - reset       in   1       synchronous, active-high
// - addr_valid  in   1       upstream issued an element; push addr_in into address FIFO
// - addr_in     in   ADDR_W  destination address of that element
// - done_in     in   1       datapath result valid this cycle (1-cycle pulse per element)
// - result_in   in   DATA_W  datapath result; sampled only when done_in=1
// - frame_end   in   1       pulse: upstream has issued last element of this change record
// - compute_en  out  1       1 = upstream may issue a new element
// - mem_valid   out  1       write request valid
// - mem_addr    out  ADDR_W  write address (stable while mem_valid && !mem_ready)
// - mem_wdata   out  DATA_W  write data (stable while mem_valid && !mem_ready)
// - mem_ready   in   1       memory accepts write when mem_valid && mem_ready
// - frame_done  out  1       1-cycle pulse: all writes of the frame accepted
// - err_orphan  out  1       sticky: done_in seen with address FIFO empty
// - err_ovf     out  1       sticky: addr_valid seen with address FIFO full
// - wr_count    out  16      writes accepted since reset, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (sync, priority over all): both FIFOs empty, FSM=IDLE, mem_valid=0, mem_addr=0,
//   mem_wdata=0, frame_done=0, err_*=0, wr_count=0, compute_en=0 in reset cycle; 1 next cycle.
//   Reset mid-operation discards all pending addresses and writes; no partial write completes.
// - Address FIFO: push on addr_valid; pop on done_in; push+pop same cycle legal (count unchanged,
//   works at full and empty: at empty, pushed addr is NOT paired with same-cycle done_in -> orphan).
// - Pairing: on done_in with address FIFO non-empty, {head addr, result_in} pushed to write FIFO
//   the same edge. done_in with address FIFO empty: result dropped, err_orphan<=1.
// - addr_valid when address FIFO full (and no same-cycle pop): addr dropped, err_ovf<=1.
// - Write FIFO cannot overflow: compute_en guarantees room (see below); done_in when write FIFO
//   full is a protocol violation and also sets err_ovf, result dropped.
// - compute_en = !(aq_count >= AQ_DEPTH-1) && !(wq_count + aq_count >= WQ_DEPTH-1), registered
//   (1-cycle lag absorbed by the -1 margin).
// - Write FSM states: IDLE, WRITE, FLUSH.
//   IDLE : mem_valid=0. wq non-empty -> WRITE (head loaded to mem_addr/mem_wdata). frame_end
//          latched (frame_pend<=1) in any state.
//   WRITE: mem_valid=1. On mem_valid&&mem_ready: pop, wr_count++; if wq has another entry load it
//          and stay (back-to-back, one write/cycle at mem_ready=1); else -> FLUSH if frame_pend,
//          else IDLE.
//   FLUSH: wait until aq empty && wq empty; then frame_done=1 for one cycle, frame_pend<=0 -> IDLE.
//          If wq becomes non-empty -> WRITE (frame_pend retained).
//   IDLE with frame_pend && both FIFOs empty -> FLUSH.
// - Write order equals done_in order; latency done_in -> mem_valid = 2 cycles from IDLE.
// - frame_end while frame_pend already 1: merged, single frame_done.
// TESTING
// - Single element: addr_valid addr=0x005, 3 cycles later done_in result=0x000010_FFFFF0,
//   mem_ready=1 -> mem_valid 2 cycles after done_in, addr 0x005, data 0x000010_FFFFF0, wr_count=1.
// - Stall: 3 results queued, mem_ready=0 for 10 cycles -> mem_addr/wdata stable, then 3 writes on
//   consecutive cycles in issue order; compute_en low while aq+wq>=3.
// - Frame: 4 elements then frame_end, mem_ready toggling 1010 -> exactly one frame_done after 4th
//   accept, wr_count=4.
// - Orphan/overflow: done_in with empty aq -> err_orphan=1, no write; 5 addr_valid with no done ->
//   5th dropped, err_ovf=1.
// - Simultaneous push/pop at full aq (count 4) -> count stays 4, correct addr pairs, no error.
// - Reset mid-WRITE with mem_ready=0 -> next cycle mem_valid=0, FIFOs empty, wr_count=0, errs 0.

Source files
------------

// File: rtl/chngy_writeback.sv
// Write-back stage for change-in-Y updates: pairs each datapath result with its issued
// Y address, queues the pairs and writes them to Y memory over a valid/ready port.
module chngy_writeback #(
    parameter int DATA_W   = 48,
    parameter int ADDR_W   = 10,
    parameter int AQ_DEPTH = 4,
    parameter int WQ_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              addr_valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              done_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              frame_end,
    output logic              compute_en,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              frame_done,
    output logic              err_orphan,
    output logic              err_ovf,
    output logic [15:0]       wr_count
);
    localparam int AQ_AW  = $clog2(AQ_DEPTH);
    localparam int WQ_AW  = $clog2(WQ_DEPTH);
    localparam int PAIR_W = ADDR_W + DATA_W;
    localparam logic [AQ_AW:0] AQ_FULL = (AQ_AW+1)'(AQ_DEPTH);
    localparam logic [AQ_AW:0] AQ_ONE  = (AQ_AW+1)'(1);
    localparam logic [WQ_AW:0] WQ_FULL = (WQ_AW+1)'(WQ_DEPTH);
    localparam logic [WQ_AW:0] WQ_ONE  = (WQ_AW+1)'(1);

    typedef enum logic [1:0] {IDLE, WRITE, FLUSH} wbStateT;

    logic [ADDR_W-1:0] aqMem [AQ_DEPTH];
    logic [AQ_AW-1:0]  aqWrPtrReg, aqRdPtrReg;
    logic [AQ_AW:0]    aqCountReg;
    logic [PAIR_W-1:0] wqMem [WQ_DEPTH];
    logic [WQ_AW-1:0]  wqWrPtrReg, wqRdPtrReg;
    logic [WQ_AW:0]    wqCountReg;

    wbStateT           stateReg, stateNext;
    logic              framePendReg, framePendNext;
    logic              frameDoneReg, frameDoneNext;
    logic              loadHead, loadNext;
    logic [ADDR_W-1:0] memAddrReg;
    logic [DATA_W-1:0] memWdataReg;
    logic [15:0]       wrCountReg;
    logic              computeEnReg, errOrphanReg, errOvfReg;

    logic              aqEmpty, aqFull, aqPush, aqPop;
    logic              wqEmpty, wqFull, wqPush, wqPop;
    logic              memValid;
    logic [PAIR_W-1:0] loadPair;

    assign memValid = (stateReg == WRITE);
    assign aqEmpty  = (aqCountReg == '0);
    assign aqFull   = (aqCountReg == AQ_FULL);
    assign wqEmpty  = (wqCountReg == '0);
    assign wqPop    = memValid && mem_ready;
    assign wqFull   = (wqCountReg == WQ_FULL) && !wqPop;
    // A same-cycle push into an empty address FIFO is never paired with this done_in.
    assign aqPop    = done_in && !aqEmpty;
    assign aqPush   = addr_valid && (!aqFull || aqPop);
    assign wqPush   = aqPop && !wqFull;
    assign loadPair = loadNext ? wqMem[wqRdPtrReg + WQ_AW'(1)] : wqMem[wqRdPtrReg];

    always_ff @(posedge clock) begin
        if (aqPush) aqMem[aqWrPtrReg] <= addr_in;
        if (wqPush) wqMem[wqWrPtrReg] <= {aqMem[aqRdPtrReg], result_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aqWrPtrReg <= '0;
            aqRdPtrReg <= '0;
            aqCountReg <= '0;
            wqWrPtrReg <= '0;
            wqRdPtrReg <= '0;
            wqCountReg <= '0;
        end else begin
            if (aqPush) aqWrPtrReg <= aqWrPtrReg + AQ_AW'(1);
            if (aqPop)  aqRdPtrReg <= aqRdPtrReg + AQ_AW'(1);
            if (wqPush) wqWrPtrReg <= wqWrPtrReg + WQ_AW'(1);
            if (wqPop)  wqRdPtrReg <= wqRdPtrReg + WQ_AW'(1);
            case ({aqPush, aqPop})
                2'b10:   aqCountReg <= aqCountReg + AQ_ONE;
                2'b01:   aqCountReg <= aqCountReg - AQ_ONE;
                default: aqCountReg <= aqCountReg;
            endcase
            case ({wqPush, wqPop})
                2'b10:   wqCountReg <= wqCountReg + WQ_ONE;
                2'b01:   wqCountReg <= wqCountReg - WQ_ONE;
                default: wqCountReg <= wqCountReg;
            endcase
        end
    end

    // The write-port head stays in the write FIFO until accepted, so the output
    // registers are reloaded from the FIFO rather than popped into.
    always_comb begin
        stateNext     = stateReg;
        loadHead      = 1'b0;
        loadNext      = 1'b0;
        frameDoneNext = 1'b0;
        framePendNext = framePendReg || frame_end;
        case (stateReg)
            IDLE: begin
                if (!wqEmpty) begin
                    stateNext = WRITE;
                    loadHead  = 1'b1;
                end else if (framePendReg && aqEmpty) begin
                    stateNext = FLUSH;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (wqCountReg > WQ_ONE) loadNext = 1'b1;
                    else stateNext = framePendReg ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (aqEmpty && wqEmpty) begin
                    frameDoneNext = 1'b1;
                    framePendNext = 1'b0;
                    stateNext     = IDLE;
                end else if (!wqEmpty) begin
                    stateNext = WRITE;
                    loadHead  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg     <= IDLE;
            framePendReg <= 1'b0;
            frameDoneReg <= 1'b0;
            memAddrReg   <= '0;
            memWdataReg  <= '0;
            wrCountReg   <= '0;
            computeEnReg <= 1'b0;
            errOrphanReg <= 1'b0;
            errOvfReg    <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            framePendReg <= framePendNext;
            frameDoneReg <= frameDoneNext;
            if (loadHead || loadNext) begin
                memAddrReg  <= loadPair[PAIR_W-1:DATA_W];
                memWdataReg <= loadPair[DATA_W-1:0];
            end
            if (wqPop) wrCountReg <= wrCountReg + 16'd1;
            // One cycle stale; the -1 margins leave room for one more issue in flight.
            computeEnReg <= (int'(aqCountReg) < AQ_DEPTH - 1) &&
                            (int'(aqCountReg) + int'(wqCountReg) < WQ_DEPTH - 1);
            if (done_in && aqEmpty) errOrphanReg <= 1'b1;
            if ((addr_valid && aqFull && !aqPop) || (aqPop && wqFull)) errOvfReg <= 1'b1;
        end
    end

    assign compute_en = computeEnReg;
    assign mem_valid  = memValid;
    assign mem_addr   = memAddrReg;
    assign mem_wdata  = memWdataReg;
    assign frame_done = frameDoneReg;
    assign err_orphan = errOrphanReg;
    assign err_ovf    = errOvfReg;
    assign wr_count   = wrCountReg;
endmodule

// File: tb/tb_chngy_writeback.sv
// Bench for chngy_writeback: directed scenarios plus randomized traffic, all checked
// against a queue-based model of pending addresses and pending writes.
module tb_chngy_writeback;
    localparam int DATA_W   = 48;
    localparam int ADDR_W   = 10;
    localparam int AQ_DEPTH = 4;
    localparam int WQ_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset, addr_valid, done_in, frame_end, mem_ready;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] result_in;
    logic              compute_en, mem_valid, frame_done, err_orphan, err_ovf;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [15:0]       wr_count;

    always #5 clock = ~clock;

    chngy_writeback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AQ_DEPTH(AQ_DEPTH), .WQ_DEPTH(WQ_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .addr_valid(addr_valid), .addr_in(addr_in),
        .done_in(done_in), .result_in(result_in), .frame_end(frame_end),
        .compute_en(compute_en), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .frame_done(frame_done),
        .err_orphan(err_orphan), .err_ovf(err_ovf), .wr_count(wr_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int fdCount = 0;
    int fdBase;
    logic [ADDR_W-1:0]        aqModel[$];
    logic [ADDR_W+DATA_W-1:0] wqModel[$];
    logic [15:0]              expWr;
    logic                     expOrphan, expOvf, ceExp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rndData();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    // One clock: check outputs at the falling edge, advance the model by the inputs
    // presented for the coming rising edge, then release single-cycle pulses.
    task automatic cycle();
        logic              ceNext, popOk;
        logic [ADDR_W-1:0] a;
        int                aqPre;
        @(negedge clock);
        if (reset) begin
            aqModel.delete();
            wqModel.delete();
            expWr     = '0;
            expOrphan = 1'b0;
            expOvf    = 1'b0;
            ceExp     = 1'b0;
        end else begin
            chk("compute_en", 64'(compute_en), 64'(ceExp));
            chk("wr_count", 64'(wr_count), 64'(expWr));
            chk("err_orphan", 64'(err_orphan), 64'(expOrphan));
            chk("err_ovf", 64'(err_ovf), 64'(expOvf));
            if (wqModel.size() == 0) chk("no_pending_write", 64'(mem_valid), 64'(0));
            else if (mem_valid) chk("write_pair", 64'({mem_addr, mem_wdata}), 64'(wqModel[0]));
            if (frame_done) fdCount++;
            ceNext = (aqModel.size() < AQ_DEPTH - 1) &&
                     (aqModel.size() + wqModel.size() < WQ_DEPTH - 1);
            if (mem_valid && mem_ready && wqModel.size() > 0) begin
                void'(wqModel.pop_front());
                expWr++;
            end
            aqPre = aqModel.size();
            popOk = done_in && (aqPre > 0);
            if (done_in) begin
                if (!popOk) expOrphan = 1'b1;
                else begin
                    a = aqModel.pop_front();
                    if (wqModel.size() >= WQ_DEPTH) expOvf = 1'b1;
                    else wqModel.push_back({a, result_in});
                end
            end
            if (addr_valid) begin
                if (aqPre >= AQ_DEPTH && !popOk) expOvf = 1'b1;
                else aqModel.push_back(addr_in);
            end
            ceExp = ceNext;
        end
        @(posedge clock);
        #1;
        addr_valid = 1'b0;
        done_in    = 1'b0;
        frame_end  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr_valid = 1'b0; done_in = 1'b0; frame_end = 1'b0;
        mem_ready = 1'b0; addr_in = '0; result_in = '0;
        expWr = '0; expOrphan = 1'b0; expOvf = 1'b0; ceExp = 1'b0;

        // Reset state
        cycle(); cycle();
        chk("reset_mem_valid", 64'(mem_valid), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        chk("reset_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("reset_frame_done", 64'(frame_done), 64'(0));
        chk("reset_wr_count", 64'(wr_count), 64'(0));
        chk("reset_compute_en", 64'(compute_en), 64'(0));
        chk("reset_errs", 64'({err_orphan, err_ovf}), 64'(0));
        reset = 1'b0;
        cycle();
        chk("ce_after_reset", 64'(compute_en), 64'(1));

        // Single element, two-cycle done->mem_valid latency
        mem_ready = 1'b1;
        addr_valid = 1'b1; addr_in = 10'h005;
        cycle(); cycle(); cycle();
        done_in = 1'b1; result_in = 48'h000010_FFFFF0;
        cycle();
        chk("single_lat1_valid", 64'(mem_valid), 64'(0));
        cycle();
        chk("single_lat2_valid", 64'(mem_valid), 64'(1));
        chk("single_addr", 64'(mem_addr), 64'h005);
        chk("single_data", 64'(mem_wdata), 64'h000010_FFFFF0);
        cycle();
        chk("single_wr_count", 64'(wr_count), 64'(1));

        // Stall with three queued writes, then back-to-back drain
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_valid = 1'b1; addr_in = 10'h040 + 10'(i);
            cycle();
            done_in = 1'b1; result_in = rndData();
            cycle();
        end
        repeat (10) cycle();
        chk("stall_ce_low", 64'(compute_en), 64'(0));
        chk("stall_valid", 64'(mem_valid), 64'(1));
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_valid", 64'(mem_valid), 64'(1));
            cycle();
        end
        chk("b2b_drained", 64'(mem_valid), 64'(0));
        chk("stall_wr_count", 64'(wr_count), 64'(4));

        // Frame of four elements with toggling mem_ready; duplicate frame_end merges
        fdBase = fdCount;
        for (int i = 0; i < 4; i++) begin
            addr_valid = 1'b1; addr_in = 10'h100 + 10'(i); mem_ready = ~mem_ready;
            cycle();
            done_in = 1'b1; result_in = rndData(); mem_ready = ~mem_ready;
            cycle();
        end
        frame_end = 1'b1; mem_ready = ~mem_ready;
        cycle();
        frame_end = 1'b1; mem_ready = ~mem_ready;
        cycle();
        repeat (20) begin
            mem_ready = ~mem_ready;
            cycle();
        end
        chk("frame_done_count", 64'(fdCount - fdBase), 64'(1));
        chk("frame_wr_count", 64'(wr_count), 64'(8));

        // Full address FIFO: push+pop, overflow, orphans
        reset = 1'b1; cycle(); reset = 1'b0; cycle();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr_valid = 1'b1; addr_in = 10'h020 + 10'(i);
            cycle();
        end
        addr_valid = 1'b1; addr_in = 10'h024; done_in = 1'b1; result_in = rndData();
        cycle();
        chk("full_pushpop_no_ovf", 64'(err_ovf), 64'(0));
        addr_valid = 1'b1; addr_in = 10'h025;
        cycle();
        chk("ovf_set", 64'(err_ovf), 64'(1));
        for (int i = 0; i < 4; i++) begin
            done_in = 1'b1; result_in = rndData();
            cycle();
        end
        repeat (4) cycle();
        chk("ovf_drain_wr_count", 64'(wr_count), 64'(5));
        done_in = 1'b1; result_in = rndData();
        cycle();
        chk("orphan_set", 64'(err_orphan), 64'(1));
        addr_valid = 1'b1; addr_in = 10'h030; done_in = 1'b1; result_in = rndData();
        cycle();
        done_in = 1'b1; result_in = rndData();
        cycle();
        repeat (4) cycle();
        chk("empty_push_kept", 64'(wr_count), 64'(6));

        // Reset while a write is stalled
        mem_ready = 1'b0;
        addr_valid = 1'b1; addr_in = 10'h3FF;
        cycle();
        done_in = 1'b1; result_in = rndData();
        cycle(); cycle();
        chk("pre_reset_valid", 64'(mem_valid), 64'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midreset_valid", 64'(mem_valid), 64'(0));
        chk("midreset_wr_count", 64'(wr_count), 64'(0));
        chk("midreset_errs", 64'({err_orphan, err_ovf}), 64'(0));
        mem_ready = 1'b1;
        repeat (5) cycle();

        // Randomized traffic that follows compute_en
        for (int n = 0; n < 800; n++) begin
            mem_ready  = ($urandom_range(0, 3) != 0);
            addr_valid = compute_en && ($urandom_range(0, 1) == 1);
            addr_in    = 10'($urandom());
            done_in    = (aqModel.size() > 0) && ($urandom_range(0, 2) != 0);
            result_in  = rndData();
            cycle();
        end
        mem_ready = 1'b1;
        for (int n = 0; n < 50 && (aqModel.size() > 0 || wqModel.size() > 0); n++) begin
            done_in   = (aqModel.size() > 0);
            result_in = rndData();
            cycle();
        end
        cycle();
        chk("drain_timeout", 64'(aqModel.size() + wqModel.size()), 64'(0));
        chk("drain_valid", 64'(mem_valid), 64'(0));
        chk("random_wr_count", 64'(wr_count), 64'(expWr));
        chk("random_errs", 64'({err_orphan, err_ovf}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
